// File: rtl/sad_min_tracker.sv
// Running minimum-SAD tracker over NUM_CH partition channels for one search window,
// recording the candidate index of each minimum; framed by a start/done handshake.
module sad_min_tracker #(
    parameter int NUM_CH   = 32,
    parameter int SAD_W    = 13,
    parameter int CAND_NUM = 64,
    parameter int IDX_W    = $clog2(CAND_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sad_valid,
    input  logic [NUM_CH*SAD_W-1:0]   sad_in,
    output logic [NUM_CH*SAD_W-1:0]   min_sad,
    output logic [NUM_CH*IDX_W-1:0]   min_idx,
    output logic [IDX_W-1:0]          cand_cnt,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAND_NUM - 1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  cand_cnt_reg, cand_cnt_next;
    logic              accept;
    logic              last_cand;

    // start always wins over a coincident sample
    assign accept    = (state_reg == SEARCH) && sad_valid && !start;
    assign last_cand = (cand_cnt_reg == LAST_IDX);

    always_comb begin
        state_next    = state_reg;
        cand_cnt_next = cand_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SEARCH;
            end
            SEARCH: begin
                if (start)                      state_next = SEARCH;
                else if (accept && last_cand)   state_next = DONE;
            end
            DONE: begin
                state_next = start ? SEARCH : IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (start)
            cand_cnt_next = '0;
        else if (accept)
            cand_cnt_next = last_cand ? '0 : cand_cnt_reg + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cand_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cand_cnt_reg <= cand_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SAD_W-1:0] min_sad_reg;
            logic [IDX_W-1:0] min_idx_reg;
            logic [SAD_W-1:0] sad_cur;

            assign sad_cur = sad_in[gi*SAD_W +: SAD_W];

            // Strict compare: ties keep the earlier index, all-ones never replaces the seed
            always_ff @(posedge clk) begin
                if (rst || start) begin
                    min_sad_reg <= '1;
                    min_idx_reg <= '0;
                end else if (accept && (sad_cur < min_sad_reg)) begin
                    min_sad_reg <= sad_cur;
                    min_idx_reg <= cand_cnt_reg;
                end
            end

            assign min_sad[gi*SAD_W +: SAD_W] = min_sad_reg;
            assign min_idx[gi*IDX_W +: IDX_W] = min_idx_reg;
        end
    endgenerate

    assign cand_cnt = cand_cnt_reg;
    assign busy     = (state_reg == SEARCH);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker: vector table, directed corner sequences and
// random traffic, all checked against a sample-history reference model.
module tb_sad_min_tracker;

    localparam int NUM_CH   = 4;
    localparam int SAD_W    = 13;
    localparam int CAND_NUM = 8;
    localparam int IDX_W    = $clog2(CAND_NUM);
    localparam int ONES     = (1 << SAD_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    sad_valid = 1'b0;
    logic [NUM_CH*SAD_W-1:0] sad_in = '0;
    logic [NUM_CH*SAD_W-1:0] min_sad;
    logic [NUM_CH*IDX_W-1:0] min_idx;
    logic [IDX_W-1:0]        cand_cnt;
    logic                    busy;
    logic                    done;

    always #5 clk = ~clk;

    sad_min_tracker #(
        .NUM_CH   (NUM_CH),
        .SAD_W    (SAD_W),
        .CAND_NUM (CAND_NUM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad_in    (sad_in),
        .min_sad   (min_sad),
        .min_idx   (min_idx),
        .cand_cnt  (cand_cnt),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: the accepted samples of the current search, in order
    logic [NUM_CH*SAD_W-1:0] hist[$];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;

    typedef struct {
        bit s; bit v; int sad0; int sad1;
        bit e_busy; bit e_done; int e_min0; int e_idx0; int e_min1; int e_idx1;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH*SAD_W-1:0] pk(input int a, input int b, input int c, input int d);
        return {SAD_W'(d), SAD_W'(c), SAD_W'(b), SAD_W'(a)};
    endfunction

    task automatic ref_best(input int c, output int m, output int idx);
        m = ONES;
        idx = 0;
        for (int i = 0; i < hist.size(); i++) begin
            int v;
            v = int'(hist[i][c*SAD_W +: SAD_W]);
            if (v < m) begin
                m = v;
                idx = i;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [NUM_CH*SAD_W-1:0] sad);
        int m, idx;
        rst = r; start = s; sad_valid = v; sad_in = sad;
        @(posedge clk);
        if (r) begin
            hist.delete(); m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (s) begin
                hist.delete(); m_busy = 1'b1;
            end else if (m_busy && v) begin
                hist.push_back(sad);
                if (hist.size() == CAND_NUM) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end
        #1;
        if (done === 1'b1) done_seen++;
        for (int c = 0; c < NUM_CH; c++) begin
            ref_best(c, m, idx);
            chk($sformatf("min_sad[%0d]", c), longint'(min_sad[c*SAD_W +: SAD_W]), longint'(m));
            chk($sformatf("min_idx[%0d]", c), longint'(min_idx[c*IDX_W +: IDX_W]), longint'(idx));
        end
        chk("cand_cnt", longint'(cand_cnt), longint'(hist.size() % CAND_NUM));
        chk("busy", longint'(busy), longint'(m_busy));
        chk("done", longint'(done), longint'(m_done));
        $display("t=%0t rst=%0b start=%0b valid=%0b sad=%h -> min_sad=%h min_idx=%h cnt=%0d busy=%0b done=%0b",
                 $time, r, s, v, sad, min_sad, min_idx, cand_cnt, busy, done);
    endtask

    initial begin
        int d0;
        int ch0_a[8];
        int ch0_b[8];

        tbl[0] = '{1, 0,   0,  0, 1, 0, ONES, 0, ONES, 0};
        tbl[1] = '{0, 1, 100, 50, 1, 0,  100, 0,   50, 0};
        tbl[2] = '{0, 1,  90, 50, 1, 0,   90, 1,   50, 0};
        tbl[3] = '{0, 1,  95, 50, 1, 0,   90, 1,   50, 0};
        tbl[4] = '{0, 1,  80, 50, 1, 0,   80, 3,   50, 0};
        tbl[5] = '{0, 1,  85, 50, 1, 0,   80, 3,   50, 0};
        tbl[6] = '{0, 1,  80, 50, 1, 0,   80, 3,   50, 0};
        tbl[7] = '{0, 1, 200, 50, 1, 0,   80, 3,   50, 0};
        tbl[8] = '{0, 1,  70, 50, 0, 1,   70, 7,   50, 0};
        tbl[9] = '{0, 0,   0,  0, 0, 0,   70, 7,   50, 0};
        ch0_a = '{100, 90, 95, 80, 85, 80, 200, 70};
        ch0_b = '{90, 80, 70, 60, 50, 40, 45, 40};

        // Reset state
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("rst_min_sad", longint'(min_sad), longint'({NUM_CH{SAD_W'(ONES)}}));
        chk("rst_min_idx", longint'(min_idx), 0);
        step(1'b0, 1'b0, 1'b1, pk(1, 1, 1, 1));

        // Full search from the vector table
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].s, tbl[i].v, pk(tbl[i].sad0, tbl[i].sad1, 1000, 7 + i));
            chk($sformatf("tbl%0d_busy", i), longint'(busy), longint'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), longint'(done), longint'(tbl[i].e_done));
            chk($sformatf("tbl%0d_min0", i), longint'(min_sad[0 +: SAD_W]), longint'(tbl[i].e_min0));
            chk($sformatf("tbl%0d_idx0", i), longint'(min_idx[0 +: IDX_W]), longint'(tbl[i].e_idx0));
            chk($sformatf("tbl%0d_min1", i), longint'(min_sad[SAD_W +: SAD_W]), longint'(tbl[i].e_min1));
            chk($sformatf("tbl%0d_idx1", i), longint'(min_idx[IDX_W +: IDX_W]), longint'(tbl[i].e_idx1));
        end

        // Gapped input: same samples, a bubble after each
        d0 = done_seen;
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, pk(ch0_a[i], 50, 300 - i, 9));
            if (i < 7) step(1'b0, 1'b0, 1'b0, pk(1, 1, 1, 1));
        end
        chk("gap_done", longint'(done), 1);
        chk("gap_min0", longint'(min_sad[0 +: SAD_W]), 70);
        chk("gap_idx0", longint'(min_idx[0 +: IDX_W]), 7);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("gap_done_count", longint'(done_seen - d0), 1);

        // Restart mid-search: stale minimum must vanish, one done only
        d0 = done_seen;
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, pk(30, 500, 500, 500));
        step(1'b0, 1'b0, 1'b1, pk(10, 500, 500, 500));
        step(1'b0, 1'b0, 1'b1, pk(20, 500, 500, 500));
        step(1'b0, 1'b1, 1'b0, '0);
        chk("restart_min0_cleared", longint'(min_sad[0 +: SAD_W]), ONES);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b1, pk(ch0_b[i], 600 - i, 600, 600));
        chk("restart_min0", longint'(min_sad[0 +: SAD_W]), 40);
        chk("restart_idx0", longint'(min_idx[0 +: IDX_W]), 5);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("restart_done_count", longint'(done_seen - d0), 1);

        // start together with sad_valid discards the sample; all-ones sample never updates
        step(1'b0, 1'b1, 1'b1, pk(100, 100, 5, 100));
        chk("startvalid_min2", longint'(min_sad[2*SAD_W +: SAD_W]), ONES);
        chk("startvalid_cnt", longint'(cand_cnt), 0);
        step(1'b0, 1'b0, 1'b1, pk(ONES, 100, 9, 100));
        chk("ones_min0", longint'(min_sad[0 +: SAD_W]), ONES);
        chk("ones_idx0", longint'(min_idx[0 +: IDX_W]), 0);
        chk("after_min2", longint'(min_sad[2*SAD_W +: SAD_W]), 9);

        // Reset mid-search after 4 samples: no done, valids in IDLE ignored
        d0 = done_seen;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, pk(20 + i, 30, 40, 50));
        step(1'b1, 1'b0, 1'b1, pk(1, 1, 1, 1));
        chk("midrst_min_sad", longint'(min_sad), longint'({NUM_CH{SAD_W'(ONES)}}));
        chk("midrst_busy", longint'(busy), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, pk(3, 3, 3, 3));
        chk("midrst_cnt", longint'(cand_cnt), 0);
        chk("midrst_no_done", longint'(done_seen - d0), 0);

        // Random traffic, small values half the time to provoke ties
        for (int i = 0; i < 800; i++) begin
            logic r, s, v;
            logic [NUM_CH*SAD_W-1:0] sad;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NUM_CH; c++)
                sad[c*SAD_W +: SAD_W] = ($urandom_range(0, 1) == 0) ? SAD_W'($urandom_range(0, 7))
                                                                    : SAD_W'($urandom);
            step(r, s, v, sad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
